extram_arbiter: RTL and testbench
=================================

# extram_arbiter

Two-port arbiter and access sequencer for the 8-bit asynchronous external SRAM. It sits between the external-RAM window of the CPU memory bus and a byte-wide DMA requester (sector-buffer fill/drain engine), and drives the single `extram_*` pin interface. It grants one requester at a time, applies round-robin fairness, stretches every access by a programmable number of wait states, and returns read data through a registered completion strobe.

## Interface
- `WAIT_STATES`, default 1: extra cycles per access beyond the minimum; legal range 0..15.
- `clk`  in  1  system clock; all logic on rising edge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `cpu_valid`  in  1  CPU request; held until `cpu_ready`.
- `cpu_we`  in  1  1 = write, 0 = read; stable while `cpu_valid`.
- `cpu_addr`  in  16  byte address.
- `cpu_wdata`  in  8  write data.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_rdata`  out  8  read data; valid while `cpu_ready`=1, held until next CPU completion.
- `dma_req`, `dma_we`, `dma_addr[15:0]`, `dma_wdata[7:0]`  in  same meaning for the DMA port.
- `dma_ack`  out  1  one-cycle completion pulse.
- `dma_rdata`  out  8  read data; valid while `dma_ack`=1, held until next DMA completion.
- `extram_a`  out  16  SRAM address.
- `extram_d_out`  out  8  SRAM write data.
- `extram_d_in`  in  8  SRAM read data.
- `extram_cs`, `extram_oe`, `extram_we`  out  1  SRAM strobes, active-high.
- `grant_dma`  out  1  1 while the current/last access belongs to DMA.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if neither request is present, stay. If one request is present, grant it. If both are present, grant the port not granted last (`last_grant` flop). Latch the winner's addr/wdata/we into output registers. Go to ACCESS and load `ws_cnt` = WAIT_STATES.
- ACCESS: drive `extram_cs`=1. Drive `extram_oe`=~we and `extram_we`=we. While `ws_cnt`≠0, decrement and stay. At `ws_cnt`=0, capture `extram_d_in` into the granted port's rdata register (reads only) and go to DONE.
- DONE: strobes low; `extram_a`/`extram_d_out` held (hold time). Pulse `cpu_ready` or `dma_ack` for exactly this cycle. Update `last_grant`. Return to IDLE.
- Reads never modify the other port's rdata register. Writes leave both rdata registers unchanged.
- Requests are sampled only in IDLE; requests arriving during ACCESS/DONE wait.
- Requester deasserting mid-access is a protocol violation; the block completes the access and still pulses the completion strobe.
- Reset values (asserted asynchronously, immediately): state IDLE; all strobes, `cpu_ready`, `dma_ack` 0; `extram_a`, `extram_d_out`, both rdata 0; `grant_dma` 0; `last_grant` = DMA, so CPU wins the first tie. Reset mid-access aborts it with no completion pulse; the requester reissues.

## Timing
- Request high in IDLE at edge n → ACCESS at cycles n+1 .. n+1+WAIT_STATES (WAIT_STATES+1 cycles of `cs`) → completion pulse in cycle n+WAIT_STATES+2.
- WAIT_STATES=1: access occupies 4 cycles including IDLE; `cs` high 2 cycles; ready 3 cycles after request.
- Back-to-back: the next arbitration occurs in the IDLE cycle after DONE. Throughput is one access per WAIT_STATES+3 cycles.
- All outputs are registered. No combinational path exists from any input to any output.
- `extram_a` is stable from the first ACCESS cycle through DONE. `extram_we` is never high in DONE or IDLE.

## Test plan
- Reset: hold `nrst`=0 with both requests high → all outputs 0. Release → CPU granted first (`grant_dma`=0).
- CPU write then read, WAIT_STATES=1: write 0x5A to 0x1234 → `cpu_ready` 3 cycles after `cpu_valid` with `extram_we` high 2 cycles. Read 0x1234 with SRAM model → `cpu_rdata`=0x5A with `dma_rdata` unchanged.
- Contention: `cpu_valid` and `dma_req` held continuously for 6 accesses → grants alternate CPU, DMA, CPU, …; each port completes 3 accesses; no overlap of `cs` between grants.
- WAIT_STATES=0 and 15: single read → `cs` high 1 and 16 cycles respectively; completion at request+2 and request+17.
- Late arrival: `dma_req` rises during a CPU ACCESS → DMA is served in the next IDLE; `dma_ack` arrives WAIT_STATES+3 cycles after CPU `cpu_ready`.
- Reset mid-access: assert `nrst`=0 during the second ACCESS cycle → strobes drop the same cycle and no `cpu_ready` is seen. After release, the reissued request completes normally.

Source files
------------

// File: rtl/extram_arbiter.sv
// extram_arbiter: two-port (CPU / DMA) round-robin arbiter and wait-state
// access sequencer for the byte-wide asynchronous external SRAM.
// Every output comes straight from a flop; there is no input-to-output path.
module extram_arbiter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        nrst,
  // CPU external-RAM window
  input  logic        cpu_valid,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ready,
  output logic [7:0]  cpu_rdata,
  // DMA sector-buffer engine
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_ack,
  output logic [7:0]  dma_rdata,
  // SRAM pins
  output logic [15:0] extram_a,
  output logic [7:0]  extram_d_out,
  input  logic [7:0]  extram_d_in,
  output logic        extram_cs,
  output logic        extram_oe,
  output logic        extram_we,
  output logic        grant_dma
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

  state_t      r_state;
  state_t      w_state_nxt;

  logic [3:0]  r_ws_cnt;
  logic [3:0]  w_ws_cnt_nxt;
  logic        r_last_dma;
  logic        w_last_dma_nxt;
  logic        r_grant_dma;
  logic        w_grant_dma_nxt;
  logic [15:0] r_a;
  logic [15:0] w_a_nxt;
  logic [7:0]  r_d_out;
  logic [7:0]  w_d_out_nxt;
  logic        r_cs;
  logic        w_cs_nxt;
  logic        r_oe;
  logic        w_oe_nxt;
  logic        r_we;
  logic        w_we_nxt;
  logic        r_cpu_ready;
  logic        w_cpu_ready_nxt;
  logic        r_dma_ack;
  logic        w_dma_ack_nxt;
  logic [7:0]  r_cpu_rdata;
  logic [7:0]  w_cpu_rdata_nxt;
  logic [7:0]  r_dma_rdata;
  logic [7:0]  w_dma_rdata_nxt;

  logic        w_pick_dma;
  logic        w_acc_we;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration and sequencing; computes the next value of every registered
  // output so that the pins change on the same edge as the state.
  always_comb begin
    w_state_nxt     = r_state;
    w_ws_cnt_nxt    = r_ws_cnt;
    w_last_dma_nxt  = r_last_dma;
    w_grant_dma_nxt = r_grant_dma;
    w_a_nxt         = r_a;
    w_d_out_nxt     = r_d_out;
    w_cs_nxt        = r_cs;
    w_oe_nxt        = r_oe;
    w_we_nxt        = r_we;
    w_cpu_ready_nxt = 1'b0;
    w_dma_ack_nxt   = 1'b0;
    w_cpu_rdata_nxt = r_cpu_rdata;
    w_dma_rdata_nxt = r_dma_rdata;

    // DMA wins when it is alone, or on a tie when CPU was served last
    w_pick_dma = dma_req & (~cpu_valid | ~r_last_dma);
    w_acc_we   = w_pick_dma ? dma_we : cpu_we;

    unique case (r_state)
      S_IDLE: begin
        if (cpu_valid | dma_req) begin
          w_grant_dma_nxt = w_pick_dma;
          w_a_nxt         = w_pick_dma ? dma_addr  : cpu_addr;
          w_d_out_nxt     = w_pick_dma ? dma_wdata : cpu_wdata;
          w_cs_nxt        = 1'b1;
          w_oe_nxt        = ~w_acc_we;
          w_we_nxt        = w_acc_we;
          w_ws_cnt_nxt    = WS_INIT;
          w_state_nxt     = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (r_ws_cnt != '0) begin
          w_ws_cnt_nxt = r_ws_cnt - 4'd1;
        end else begin
          w_cs_nxt = 1'b0;
          w_oe_nxt = 1'b0;
          w_we_nxt = 1'b0;
          // r_oe marks a read; only the granted port's rdata is touched
          if (r_oe) begin
            if (r_grant_dma) begin
              w_dma_rdata_nxt = extram_d_in;
            end else begin
              w_cpu_rdata_nxt = extram_d_in;
            end
          end
          if (r_grant_dma) begin
            w_dma_ack_nxt = 1'b1;
          end else begin
            w_cpu_ready_nxt = 1'b1;
          end
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_last_dma_nxt = r_grant_dma;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output and bookkeeping registers; reset leaves CPU as the first tie winner
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_ws_cnt    <= '0;
      r_last_dma  <= 1'b1;
      r_grant_dma <= 1'b0;
      r_a         <= '0;
      r_d_out     <= '0;
      r_cs        <= 1'b0;
      r_oe        <= 1'b0;
      r_we        <= 1'b0;
      r_cpu_ready <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
    end else begin
      r_ws_cnt    <= w_ws_cnt_nxt;
      r_last_dma  <= w_last_dma_nxt;
      r_grant_dma <= w_grant_dma_nxt;
      r_a         <= w_a_nxt;
      r_d_out     <= w_d_out_nxt;
      r_cs        <= w_cs_nxt;
      r_oe        <= w_oe_nxt;
      r_we        <= w_we_nxt;
      r_cpu_ready <= w_cpu_ready_nxt;
      r_dma_ack   <= w_dma_ack_nxt;
      r_cpu_rdata <= w_cpu_rdata_nxt;
      r_dma_rdata <= w_dma_rdata_nxt;
    end
  end

  assign cpu_ready    = r_cpu_ready;
  assign cpu_rdata    = r_cpu_rdata;
  assign dma_ack      = r_dma_ack;
  assign dma_rdata    = r_dma_rdata;
  assign extram_a     = r_a;
  assign extram_d_out = r_d_out;
  assign extram_cs    = r_cs;
  assign extram_oe    = r_oe;
  assign extram_we    = r_we;
  assign grant_dma    = r_grant_dma;

endmodule

// File: tb/tb_extram_arbiter.sv
// Testbench for extram_arbiter: three instances (WAIT_STATES 1, 0, 15), each
// with its own SRAM model, checked against a memory/timing reference model.
module tb_extram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst      [3];
  logic        cpu_valid [3];
  logic        cpu_we    [3];
  logic [15:0] cpu_addr  [3];
  logic [7:0]  cpu_wdata [3];
  logic        cpu_ready [3];
  logic [7:0]  cpu_rdata [3];
  logic        dma_req   [3];
  logic        dma_we    [3];
  logic [15:0] dma_addr  [3];
  logic [7:0]  dma_wdata [3];
  logic        dma_ack   [3];
  logic [7:0]  dma_rdata [3];
  logic [15:0] ext_a     [3];
  logic [7:0]  ext_dout  [3];
  logic [7:0]  ext_din   [3];
  logic        ext_cs    [3];
  logic        ext_oe    [3];
  logic        ext_we    [3];
  logic        grant_dma [3];

  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned WSV = (g == 0) ? 1 : ((g == 1) ? 0 : 15);
    extram_arbiter #(.WAIT_STATES(WSV)) u_dut (
      .clk(clk), .nrst(nrst[g]),
      .cpu_valid(cpu_valid[g]), .cpu_we(cpu_we[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_ready(cpu_ready[g]), .cpu_rdata(cpu_rdata[g]),
      .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]),
      .dma_wdata(dma_wdata[g]), .dma_ack(dma_ack[g]), .dma_rdata(dma_rdata[g]),
      .extram_a(ext_a[g]), .extram_d_out(ext_dout[g]), .extram_d_in(ext_din[g]),
      .extram_cs(ext_cs[g]), .extram_oe(ext_oe[g]), .extram_we(ext_we[g]),
      .grant_dma(grant_dma[g])
    );
  end

  function automatic int ws_of(input int k);
    if (k == 0) return 1;
    if (k == 1) return 0;
    return 15;
  endfunction

  // Background content of never-written SRAM locations
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // SRAM models
  logic [7:0] sram    [3][65536];
  logic       wr_flag [3][65536];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (ext_we[k] === 1'b1) begin
        sram[k][ext_a[k]]    <= ext_dout[k];
        wr_flag[k][ext_a[k]] <= 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      ext_din[k] = (wr_flag[k][ext_a[k]] === 1'b1) ? sram[k][ext_a[k]] : pat(ext_a[k]);
    end
  end

  // Reference memory contents, updated when a write completes
  logic [7:0] gold [int];

  function automatic logic [7:0] exp_rd(input int k, input logic [15:0] a);
    int key;
    key = k * 65536 + int'(a);
    if (gold.exists(key)) return gold[key];
    return pat(a);
  endfunction

  function automatic logic [15:0] rnd_addr();
    return 16'h1200 + 16'($urandom_range(0, 15));
  endfunction

  // Protocol monitor: quiet strobes on completion, stable grant/address while cs
  logic        prev_cs    [3];
  logic        prev_grant [3];
  logic [15:0] prev_a     [3];

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (cpu_ready[k] || dma_ack[k]) begin
        checks++;
        if ({ext_cs[k], ext_oe[k], ext_we[k]} !== 3'b000) begin
          errors++;
          $display("FAIL done_strobes inst%0d: got %b expected 000", k,
                   {ext_cs[k], ext_oe[k], ext_we[k]});
        end
        checks++;
        if ((cpu_ready[k] && dma_ack[k]) !== 1'b0) begin
          errors++;
          $display("FAIL dual_complete inst%0d: got both strobes expected one", k);
        end
      end
      if (ext_cs[k] === 1'b1 && prev_cs[k] === 1'b1) begin
        checks++;
        if (grant_dma[k] !== prev_grant[k] || ext_a[k] !== prev_a[k]) begin
          errors++;
          $display("FAIL cs_stable inst%0d: got grant %b a %h expected grant %b a %h", k,
                   grant_dma[k], ext_a[k], prev_grant[k], prev_a[k]);
        end
      end
      if (ext_we[k] === 1'b1) begin
        checks++;
        if (ext_cs[k] !== 1'b1) begin
          errors++;
          $display("FAIL we_without_cs inst%0d: got cs %b expected 1", k, ext_cs[k]);
        end
      end
      prev_cs[k]    <= ext_cs[k];
      prev_grant[k] <= grant_dma[k];
      prev_a[k]     <= ext_a[k];
    end
  end

  // Single access on one port; returns completion latency in cycles counted
  // from the edge that samples the request (-1 on timeout), plus strobe counts.
  task automatic do_access(input int k, input bit dma, input bit we,
                           input logic [15:0] addr, input logic [7:0] wd,
                           output int lat, output int ncs, output int nwe,
                           output logic [7:0] rd);
    @(negedge clk);
    if (dma) begin
      dma_req[k] = 1'b1; dma_we[k] = we; dma_addr[k] = addr; dma_wdata[k] = wd;
    end else begin
      cpu_valid[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = addr; cpu_wdata[k] = wd;
    end
    lat = -1; ncs = 0; nwe = 0;
    for (int c = 1; c <= 64; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ext_cs[k]) ncs++;
      if (ext_we[k]) nwe++;
      if (dma ? dma_ack[k] : cpu_ready[k]) begin
        lat = c;
        break;
      end
    end
    rd = dma ? dma_rdata[k] : cpu_rdata[k];
    if (we && lat > 0) gold[k * 65536 + int'(addr)] = wd;
    dma_req[k]   = 1'b0;
    cpu_valid[k] = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    int ws;
    int c;
    logic [15:0] ca, da;
    ws = ws_of(0);
    ca = rnd_addr();
    da = rnd_addr();
    @(negedge clk);
    cpu_valid[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = ca;
    dma_req[0]   = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = da;
    repeat (2) @(negedge clk);
    checks++;
    if ({ext_cs[0], ext_oe[0], ext_we[0], cpu_ready[0], dma_ack[0], grant_dma[0]} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {ext_cs[0], ext_oe[0], ext_we[0], cpu_ready[0], dma_ack[0], grant_dma[0]});
    end
    checks++;
    if (ext_a[0] !== 16'h0) begin
      errors++; $display("FAIL reset_addr: got %h expected 0000", ext_a[0]);
    end
    checks++;
    if (ext_dout[0] !== 8'h0) begin
      errors++; $display("FAIL reset_dout: got %h expected 00", ext_dout[0]);
    end
    checks++;
    if (cpu_rdata[0] !== 8'h0 || dma_rdata[0] !== 8'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h/%h expected 00/00", cpu_rdata[0], dma_rdata[0]);
    end
    nrst[0] = 1'b1; nrst[1] = 1'b1; nrst[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant_dma[0] !== 1'b0 || ext_cs[0] !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: got grant %b cs %b expected grant 0 cs 1",
               grant_dma[0], ext_cs[0]);
    end
    c = 1;
    while (!cpu_ready[0] && c < 40) begin
      @(posedge clk); @(negedge clk); c++;
    end
    checks++;
    if (c !== ws + 2 || cpu_rdata[0] !== exp_rd(0, ca)) begin
      errors++;
      $display("FAIL first_cpu: got cycle %0d data %h expected cycle %0d data %h",
               c, cpu_rdata[0], ws + 2, exp_rd(0, ca));
    end
    cpu_valid[0] = 1'b0;
    while (!dma_ack[0] && c < 80) begin
      @(posedge clk); @(negedge clk); c++;
    end
    checks++;
    if (c !== 2 * ws + 5 || dma_rdata[0] !== exp_rd(0, da)) begin
      errors++;
      $display("FAIL then_dma: got cycle %0d data %h expected cycle %0d data %h",
               c, dma_rdata[0], 2 * ws + 5, exp_rd(0, da));
    end
    dma_req[0] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_write_read();
    int lat, ncs, nwe;
    logic [7:0] rd, dma_before;
    do_access(0, 1'b0, 1'b1, 16'h1234, 8'h5A, lat, ncs, nwe, rd);
    checks++;
    if (lat !== 3 || ncs !== 2 || nwe !== 2) begin
      errors++;
      $display("FAIL cpu_write: got lat %0d cs %0d we %0d expected 3 2 2", lat, ncs, nwe);
    end
    dma_before = dma_rdata[0];
    do_access(0, 1'b0, 1'b0, 16'h1234, 8'h00, lat, ncs, nwe, rd);
    checks++;
    if (lat !== 3 || nwe !== 0 || rd !== 8'h5A) begin
      errors++;
      $display("FAIL cpu_read: got lat %0d we %0d data %h expected 3 0 5a", lat, nwe, rd);
    end
    checks++;
    if (dma_rdata[0] !== dma_before) begin
      errors++;
      $display("FAIL dma_rdata_kept: got %h expected %h", dma_rdata[0], dma_before);
    end
  endtask

  task automatic test_random(input int k, input int n);
    int ws, lat, ncs, nwe;
    bit dma, we;
    logic [15:0] a;
    logic [7:0] wd, rd, exp, other_before, self_before;
    ws = ws_of(k);
    for (int i = 0; i < n; i++) begin
      dma = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      a   = rnd_addr();
      wd  = 8'($urandom);
      exp = exp_rd(k, a);
      other_before = dma ? cpu_rdata[k] : dma_rdata[k];
      self_before  = dma ? dma_rdata[k] : cpu_rdata[k];
      do_access(k, dma, we, a, wd, lat, ncs, nwe, rd);
      checks++;
      if (lat !== ws + 2 || ncs !== ws + 1 || nwe !== (we ? ws + 1 : 0)) begin
        errors++;
        $display("FAIL rand_timing inst%0d: got lat %0d cs %0d we %0d expected %0d %0d %0d",
                 k, lat, ncs, nwe, ws + 2, ws + 1, we ? ws + 1 : 0);
      end
      checks++;
      if (rd !== (we ? self_before : exp)) begin
        errors++;
        $display("FAIL rand_rdata inst%0d: got %h expected %h", k, rd, we ? self_before : exp);
      end
      checks++;
      if ((dma ? cpu_rdata[k] : dma_rdata[k]) !== other_before) begin
        errors++;
        $display("FAIL rand_other_rdata inst%0d: got %h expected %h", k,
                 dma ? cpu_rdata[k] : dma_rdata[k], other_before);
      end
    end
  endtask

  task automatic test_contention();
    int ws, done_n, n_cpu, n_dma, last_c;
    bit exp_dma;
    logic [15:0] ca, da;
    logic        cw, dw;
    logic [7:0]  cd, dd;
    ws = ws_of(0);
    done_n = 0; n_cpu = 0; n_dma = 0; last_c = -1; exp_dma = 1'b0;
    @(negedge clk); nrst[0] = 1'b0;
    @(negedge clk); nrst[0] = 1'b1;
    ca = rnd_addr(); cw = 1'($urandom_range(0, 1)); cd = 8'($urandom);
    da = rnd_addr(); dw = 1'($urandom_range(0, 1)); dd = 8'($urandom);
    cpu_valid[0] = 1'b1; cpu_we[0] = cw; cpu_addr[0] = ca; cpu_wdata[0] = cd;
    dma_req[0]   = 1'b1; dma_we[0] = dw; dma_addr[0] = da; dma_wdata[0] = dd;
    for (int c = 1; c <= 200 && done_n < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (cpu_ready[0] || dma_ack[0]) begin
        bit is_dma;
        is_dma = dma_ack[0];
        checks++;
        if (is_dma !== exp_dma) begin
          errors++;
          $display("FAIL rr_order #%0d: got dma=%b expected dma=%b", done_n, is_dma, exp_dma);
        end
        checks++;
        if (c - last_c !== ((last_c < 0) ? ws + 2 + 1 : ws + 3)) begin
          errors++;
          $display("FAIL rr_spacing #%0d: got %0d expected %0d", done_n, c - last_c,
                   (last_c < 0) ? ws + 3 : ws + 3);
        end
        if (is_dma) begin
          if (!dw) begin
            checks++;
            if (dma_rdata[0] !== exp_rd(0, da)) begin
              errors++;
              $display("FAIL rr_dma_data: got %h expected %h", dma_rdata[0], exp_rd(0, da));
            end
          end else begin
            gold[int'(da)] = dd;
          end
          n_dma++;
          da = rnd_addr(); dw = 1'($urandom_range(0, 1)); dd = 8'($urandom);
          dma_we[0] = dw; dma_addr[0] = da; dma_wdata[0] = dd;
        end else begin
          if (!cw) begin
            checks++;
            if (cpu_rdata[0] !== exp_rd(0, ca)) begin
              errors++;
              $display("FAIL rr_cpu_data: got %h expected %h", cpu_rdata[0], exp_rd(0, ca));
            end
          end else begin
            gold[int'(ca)] = cd;
          end
          n_cpu++;
          ca = rnd_addr(); cw = 1'($urandom_range(0, 1)); cd = 8'($urandom);
          cpu_we[0] = cw; cpu_addr[0] = ca; cpu_wdata[0] = cd;
        end
        last_c = c;
        exp_dma = ~exp_dma;
        done_n++;
      end
    end
    cpu_valid[0] = 1'b0;
    dma_req[0]   = 1'b0;
    checks++;
    if (n_cpu !== 3 || n_dma !== 3) begin
      errors++;
      $display("FAIL rr_counts: got cpu %0d dma %0d expected 3 3", n_cpu, n_dma);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_late_arrival();
    int ws, c, c_cpu;
    logic [15:0] ca, da;
    ws = ws_of(0);
    ca = rnd_addr();
    da = rnd_addr();
    @(negedge clk);
    cpu_valid[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = ca;
    @(posedge clk);
    @(negedge clk);
    c = 1;
    dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = da;
    while (!cpu_ready[0] && c < 40) begin
      @(posedge clk); @(negedge clk); c++;
    end
    c_cpu = c;
    cpu_valid[0] = 1'b0;
    checks++;
    if (grant_dma[0] !== 1'b0 || c_cpu !== ws + 2) begin
      errors++;
      $display("FAIL late_cpu: got grant %b cycle %0d expected 0 %0d", grant_dma[0], c_cpu, ws + 2);
    end
    while (!dma_ack[0] && c < 80) begin
      @(posedge clk); @(negedge clk); c++;
    end
    dma_req[0] = 1'b0;
    checks++;
    if (c - c_cpu !== ws + 3 || dma_rdata[0] !== exp_rd(0, da)) begin
      errors++;
      $display("FAIL late_dma: got gap %0d data %h expected %0d %h", c - c_cpu,
               dma_rdata[0], ws + 3, exp_rd(0, da));
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, ncs, nwe;
    bit seen;
    logic [15:0] a;
    logic [7:0] rd;
    a = rnd_addr();
    @(negedge clk);
    cpu_valid[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = a;
    @(posedge clk);
    @(posedge clk);
    #2 nrst[0] = 1'b0;
    #1;
    checks++;
    if ({ext_cs[0], ext_oe[0], ext_we[0], cpu_ready[0]} !== 4'b0 || ext_a[0] !== 16'h0) begin
      errors++;
      $display("FAIL mid_reset_strobes: got %b a %h expected 0000 a 0000",
               {ext_cs[0], ext_oe[0], ext_we[0], cpu_ready[0]}, ext_a[0]);
    end
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ready[0]) seen = 1'b1;
    end
    cpu_valid[0] = 1'b0;
    nrst[0] = 1'b1;
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ready: got 1 expected 0");
    end
    @(posedge clk);
    do_access(0, 1'b0, 1'b0, a, 8'h00, lat, ncs, nwe, rd);
    checks++;
    if (lat !== ws_of(0) + 2 || rd !== exp_rd(0, a)) begin
      errors++;
      $display("FAIL mid_reset_reissue: got lat %0d data %h expected %0d %h",
               lat, rd, ws_of(0) + 2, exp_rd(0, a));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      nrst[k] = 1'b0;
      cpu_valid[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
      dma_req[k]   = 1'b0; dma_we[k] = 1'b0; dma_addr[k] = '0; dma_wdata[k] = '0;
    end
    test_reset();
    test_write_read();
    test_random(0, 24);
    test_contention();
    test_random(1, 12);
    test_random(2, 6);
    test_late_arrival();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
